mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_arb_rr2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the I/D main-memory arbiter.
//   state_t : arbiter sequencing states (IDLE, BUSY, DONE)
//   owner_t : which cache refill port owns the memory (OWN_I / OWN_D)
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WD_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-way round-robin pick between the I-side and D-side requesters.
//   req_i, req_d : pending requests
//   last_grant   : side that completed the most recent transaction
//   grant_d      : 1 = D wins, 0 = I wins (only meaningful when a request exists)
module arb_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   grant_d
);

    // D wins when alone, or on a tie when I was served last.
    assign grant_d = req_d & (~req_i | (last_grant == OWN_I));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single main memory between the I-cache refill port (read
// only) and the D-cache refill/write-back port, one transaction at a time.
//   CLK, RESET                : clock, asynchronous active-low reset
//   i_read/i_address          : I-side request; i_readdata/i_busywait back
//   d_read/d_write/d_address/
//   d_writedata               : D-side request; d_readdata/d_busywait back
//   mem_*                     : registered command/data to memory, busy/data in
//   timeout_err               : sticky flag, memory never finished a command
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    state_t          state;
    owner_t          owner;
    owner_t          last_grant;
    logic [WD_W-1:0] wd_cnt;
    logic            seen_busy;
    logic            d_req;
    logic            grant_d;

    assign d_req = d_read | d_write;

    arb_rr2 u_arb (
        .req_i      (i_read),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant_d    (grant_d)
    );

    // Requesters stall until the single DONE cycle of their own transaction.
    assign i_busywait = i_read & ~((state == ST_DONE) & (owner == OWN_I));
    assign d_busywait = d_req  & ~((state == ST_DONE) & (owner == OWN_D));

    // Sequencer: grant in IDLE, hold command in BUSY, release owner in DONE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= ST_IDLE;
            owner         <= OWN_I;
            last_grant    <= OWN_I;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
            wd_cnt        <= '0;
            seen_busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_read | d_req) begin
                        state     <= ST_BUSY;
                        wd_cnt    <= '0;
                        seen_busy <= 1'b0;
                        if (grant_d) begin
                            owner         <= OWN_D;
                            mem_address   <= d_address;
                            mem_writedata <= d_writedata;
                            // write-back takes precedence over a refill read
                            mem_write     <= d_write;
                            mem_read      <= ~d_write;
                        end else begin
                            owner         <= OWN_I;
                            mem_address   <= i_address;
                            mem_read      <= 1'b1;
                            mem_write     <= 1'b0;
                        end
                    end
                end

                ST_BUSY: begin
                    // Completion needs a busy phase first, so a memory that has
                    // not yet reacted to the new command is not mistaken as done.
                    if (seen_busy && !mem_busywait) begin
                        if (mem_read) begin
                            if (owner == OWN_D) begin
                                d_readdata <= mem_readdata;
                            end else begin
                                i_readdata <= mem_readdata;
                            end
                        end
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        seen_busy  <= 1'b0;
                        wd_cnt     <= '0;
                        last_grant <= owner;
                        state      <= ST_DONE;
                    end else if (wd_cnt == WD_W'(TIMEOUT)) begin
                        // Abort: release the owner without touching readdata.
                        timeout_err <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        seen_busy   <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= ST_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (mem_busywait) begin
                            seen_busy <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a small busywait
// memory responder; inputs driven and outputs sampled on the falling edge.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          CLK;
    logic          RESET;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_readdata;
    logic          i_busywait;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_writedata;
    logic [DW-1:0] d_readdata;
    logic          d_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic          timeout_err;

    int            n_cmp;
    int            n_bad;

    // memory responder controls (written by tests, read by the responder)
    int            mem_lat;
    bit            mem_hang;
    logic [DW-1:0] mem_rdata;

    mem_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .timeout_err   (timeout_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory: raises busywait the cycle after a command, holds it mem_lat
    // cycles (forever while mem_hang), then drops it and presents mem_rdata.
    initial begin
        int busy_cnt;
        busy_cnt     = 0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        forever begin
            @(negedge CLK);
            if (mem_busywait) begin
                if (busy_cnt > 0) busy_cnt--;
                if (busy_cnt == 0 && !mem_hang) begin
                    mem_busywait = 1'b0;
                    mem_readdata = mem_rdata;
                end
            end else if (mem_read || mem_write) begin
                mem_busywait = 1'b1;
                busy_cnt     = mem_lat;
            end
        end
    end

    // Wait for one side's busywait to drop; cycles = -1 if it never does.
    task automatic wait_release(input bit side_d, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if ((side_d ? d_busywait : i_busywait) == 1'b0) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        mem_lat = 5; mem_hang = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({mem_read, mem_write, mem_address, mem_writedata} !== '0) begin
            n_bad++; $display("FAIL reset_mem: got r=%b w=%b a=%h d=%h exp all 0", mem_read, mem_write, mem_address, mem_writedata);
        end
        n_cmp++;
        if ({i_readdata, d_readdata, timeout_err} !== '0) begin
            n_bad++; $display("FAIL reset_out: got i=%h d=%h to=%b exp all 0", i_readdata, d_readdata, timeout_err);
        end
        RESET = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({i_busywait, d_busywait} !== 2'b00) begin
            n_bad++; $display("FAIL reset_idle_busy: got %b exp 00", {i_busywait, d_busywait});
        end
    endtask

    task automatic test_single_i_read();
        int cyc;
        mem_lat = 5; mem_rdata = 32'hA1B2C3D4;
        i_read = 1'b1; i_address = 6'h05;
        @(negedge CLK);
        n_cmp++;
        if ({mem_read, mem_write, mem_address, i_busywait} !== {1'b1, 1'b0, 6'h05, 1'b1}) begin
            n_bad++; $display("FAIL i_read_cmd: got r=%b w=%b a=%h bw=%b exp 1 0 05 1", mem_read, mem_write, mem_address, i_busywait);
        end
        wait_release(1'b0, 30, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_bad++; $display("FAIL i_read_latency: got %0d exp 6", cyc);
        end
        n_cmp++;
        if (i_readdata !== 32'hA1B2C3D4) begin
            n_bad++; $display("FAIL i_read_data: got %h exp a1b2c3d4", i_readdata);
        end
        n_cmp++;
        if (mem_read !== 1'b0) begin
            n_bad++; $display("FAIL i_read_cmd_clear: got %b exp 0", mem_read);
        end
        i_read = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_late_request();
        int cyc;
        bit ok;
        mem_lat = 3; mem_rdata = 32'h11112222;
        i_read = 1'b1; i_address = 6'h0C;
        @(negedge CLK);
        @(negedge CLK);
        d_read = 1'b1; d_address = 6'h21;
        ok = 1'b1; cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (d_busywait !== 1'b1 || (mem_read === 1'b1 && mem_address !== 6'h0C)) ok = 1'b0;
            if (i_busywait == 1'b0) begin
                cyc = i;
                break;
            end
        end
        n_cmp++;
        if (!ok || cyc < 0) begin
            n_bad++; $display("FAIL late_d_waits: got ok=%b cyc=%0d exp ok=1 cyc>=0", ok, cyc);
        end
        n_cmp++;
        if (i_readdata !== 32'h11112222) begin
            n_bad++; $display("FAIL late_i_data: got %h exp 11112222", i_readdata);
        end
        i_read = 1'b0;
        mem_rdata = 32'h33334444;
        @(negedge CLK);
        n_cmp++;
        if ({mem_read, d_busywait} !== 2'b01) begin
            n_bad++; $display("FAIL late_no_early_d: got r=%b dbw=%b exp 0 1", mem_read, d_busywait);
        end
        @(negedge CLK);
        n_cmp++;
        if ({mem_read, mem_address} !== {1'b1, 6'h21}) begin
            n_bad++; $display("FAIL late_d_grant: got r=%b a=%h exp 1 21", mem_read, mem_address);
        end
        wait_release(1'b1, 30, cyc);
        n_cmp++;
        if (cyc < 0 || d_readdata !== 32'h33334444) begin
            n_bad++; $display("FAIL late_d_data: got %h cyc=%0d exp 33334444", d_readdata, cyc);
        end
        d_read = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_d_write();
        int cyc;
        bit ok;
        mem_lat = 4; mem_rdata = 32'h55556666;
        d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'hDEADBEEF;
        @(negedge CLK);
        n_cmp++;
        if ({mem_write, mem_read, mem_address, mem_writedata} !== {1'b1, 1'b0, 6'h3F, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL d_write_cmd: got w=%b r=%b a=%h d=%h exp 1 0 3f deadbeef", mem_write, mem_read, mem_address, mem_writedata);
        end
        d_writedata = 32'h0;
        ok = 1'b1; cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (d_busywait == 1'b0) begin
                cyc = i;
                break;
            end
            if ({mem_write, mem_address, mem_writedata} !== {1'b1, 6'h3F, 32'hDEADBEEF}) ok = 1'b0;
        end
        n_cmp++;
        if (!ok || cyc < 0) begin
            n_bad++; $display("FAIL d_write_stable: got ok=%b cyc=%0d exp ok=1 cyc>=0", ok, cyc);
        end
        n_cmp++;
        if ({d_readdata, mem_write} !== {32'h33334444, 1'b0}) begin
            n_bad++; $display("FAIL d_write_done: got rd=%h w=%b exp 33334444 0", d_readdata, mem_write);
        end
        d_write = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (d_busywait !== 1'b0) begin
            n_bad++; $display("FAIL d_write_release: got %b exp 0", d_busywait);
        end
    endtask

    task automatic test_mid_reset();
        mem_lat = 5; mem_rdata = 32'h77778888;
        i_read = 1'b1; i_address = 6'h0A;
        @(negedge CLK);
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_bad++; $display("FAIL midrst_pre: got %b exp 1", mem_read);
        end
        #2 RESET = 1'b0;
        #1;
        n_cmp++;
        if ({mem_read, mem_write, mem_address, mem_writedata, i_readdata, d_readdata, timeout_err} !== '0) begin
            n_bad++; $display("FAIL midrst_async: got r=%b a=%h wd=%h i=%h d=%h exp all 0", mem_read, mem_address, mem_writedata, i_readdata, d_readdata);
        end
        i_read = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (8) @(negedge CLK);
        n_cmp++;
        if ({mem_read, i_busywait, i_readdata} !== '0) begin
            n_bad++; $display("FAIL midrst_dropped: got r=%b bw=%b i=%h exp 0 0 0", mem_read, i_busywait, i_readdata);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_d;
        mem_lat = 2; mem_rdata = 32'hCAFE0001;
        i_read = 1'b1; i_address = 6'h01;
        d_read = 1'b1; d_address = 6'h02;
        @(negedge CLK);
        n_cmp++;
        if ({mem_read, mem_address, i_busywait} !== {1'b1, 6'h02, 1'b1}) begin
            n_bad++; $display("FAIL tie_first_d: got r=%b a=%h ibw=%b exp 1 02 1", mem_read, mem_address, i_busywait);
        end
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            for (int t = 0; t < 30; t++) begin
                if (i_busywait == 1'b0 || d_busywait == 1'b0) break;
                @(negedge CLK);
            end
            n_cmp++;
            if ({i_busywait, d_busywait} !== (exp_d ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rr_order_%0d: got ibw,dbw=%b exp %b", k, {i_busywait, d_busywait}, exp_d ? 2'b10 : 2'b01);
            end
            if (k == 0) begin
                n_cmp++;
                if (d_readdata !== 32'hCAFE0001) begin
                    n_bad++; $display("FAIL rr_d_data: got %h exp cafe0001", d_readdata);
                end
            end
            if (k == 3) begin
                i_read = 1'b0; d_read = 1'b0;
            end else if (exp_d) begin
                d_read = 1'b0;
                @(negedge CLK);
                d_read = 1'b1;
            end else begin
                i_read = 1'b0;
                @(negedge CLK);
                i_read = 1'b1;
            end
            @(negedge CLK);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_hung_memory();
        int cyc;
        mem_hang = 1'b1; mem_lat = 2;
        d_read = 1'b1; d_address = 6'h11;
        @(negedge CLK);
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_bad++; $display("FAIL hung_cmd: got %b exp 1", mem_read);
        end
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (timeout_err === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_cmp++;
        if (cyc !== 9) begin
            n_bad++; $display("FAIL hung_timeout_cycle: got %0d exp 9", cyc);
        end
        n_cmp++;
        if ({mem_read, d_busywait, d_readdata} !== {1'b0, 1'b0, 32'hCAFE0001}) begin
            n_bad++; $display("FAIL hung_abort: got r=%b dbw=%b rd=%h exp 0 0 cafe0001", mem_read, d_busywait, d_readdata);
        end
        d_read = 1'b0;
        mem_hang = 1'b0;
        repeat (4) @(negedge CLK);
        mem_lat = 3; mem_rdata = 32'h0BADF00D;
        i_read = 1'b1; i_address = 6'h07;
        wait_release(1'b0, 30, cyc);
        n_cmp++;
        if ({i_readdata, timeout_err} !== {32'h0BADF00D, 1'b1} || cyc < 0) begin
            n_bad++; $display("FAIL hung_sticky: got rd=%h to=%b cyc=%0d exp 0badf00d 1", i_readdata, timeout_err, cyc);
        end
        i_read = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_i_read();
        test_late_request();
        test_d_write();
        test_mid_reset();
        test_back_to_back();
        test_hung_memory();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
